// File: rtl/microwave_keypad_scanner_if.sv
// Matrix keypad lines plus the microwave-facing digit and button levels.
interface microwave_keypad_scanner_if;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic [9:0] keypad;
  logic       startn;
  logic       stopn;
  logic       clearn;

  modport master (
    input  rows_n,
    output cols_n,
    output keypad,
    output startn,
    output stopn,
    output clearn
  );

  modport slave (
    output rows_n,
    input  cols_n,
    input  keypad,
    input  startn,
    input  stopn,
    input  clearn
  );
endinterface

// File: rtl/microwave_keypad_scanner.sv
// 4x4 keypad scanner with full-scan debounce and chord reject.
// Define KEYPAD_ONESHOT_EN to make keypad a one-clock pulse per new digit.
module microwave_keypad_scanner #(
  parameter int SCAN_DIV       = 3,
  parameter int DEBOUNCE_SCANS = 2
) (
  input logic                        clock,
  input logic                        resetn,
  microwave_keypad_scanner_if.master kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_END  = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);
  localparam logic [SW-1:0] STABLE_ONE = SW'(1);
  localparam logic [15:0]   KEY_MASK   = 16'h2FFF;

  logic [3:0]    meta;
  logic [3:0]    rows_sync;
  logic [1:0]    col;
  logic [DW-1:0] dwell;
  logic          capture;
  logic [15:0]   snapshot;
  logic [15:0]   snap_next;
  logic [15:0]   candidate;
  logic [SW-1:0] stable_cnt;
  logic          commit;

  logic [15:0]   masked;
  logic          single;
  logic [9:0]    digit_nx;
  logic          start_nx;
  logic          stop_nx;
  logic          clear_nx;

  logic [9:0]    digit_q;
  logic          start_q;
  logic          stop_q;
  logic          clear_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta      <= 4'hF;
      rows_sync <= 4'hF;
    end else begin
      meta      <= kp.rows_n;
      rows_sync <= meta;
    end
  end

  assign capture   = (dwell == DWELL_END);
  assign kp.cols_n = ~(4'b0001 << col);

  always_comb begin
    snap_next = snapshot;
    for (int b = 0; b < 16; b++) begin
      if (b[1:0] == col) begin
        snap_next[b] = ~rows_sync[b / 4];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col        <= 2'd0;
      dwell      <= '0;
      snapshot   <= '0;
      candidate  <= '0;
      stable_cnt <= '0;
    end else if (capture) begin
      dwell    <= '0;
      col      <= col + 2'd1;
      snapshot <= snap_next;
      if (col == 2'd3) begin
        if (snap_next == candidate) begin
          if (stable_cnt != STABLE_MAX) begin
            stable_cnt <= stable_cnt + STABLE_ONE;
          end
        end else begin
          candidate  <= snap_next;
          stable_cnt <= STABLE_ONE;
        end
      end
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  assign commit = (stable_cnt == STABLE_MAX);

  // More than one mapped key (chord or ghost) decodes to nothing.
  always_comb begin
    masked   = candidate & KEY_MASK;
    single   = (masked != 16'd0) &&
               ((masked & (masked - 16'd1)) == 16'd0);
    digit_nx = '0;
    start_nx = 1'b0;
    stop_nx  = 1'b0;
    clear_nx = 1'b0;
    if (single) begin
      digit_nx[1] = masked[0];
      digit_nx[2] = masked[1];
      digit_nx[3] = masked[2];
      digit_nx[4] = masked[4];
      digit_nx[5] = masked[5];
      digit_nx[6] = masked[6];
      digit_nx[7] = masked[8];
      digit_nx[8] = masked[9];
      digit_nx[9] = masked[10];
      digit_nx[0] = masked[13];
      start_nx    = masked[3];
      stop_nx     = masked[7];
      clear_nx    = masked[11];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      digit_q <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clear_q <= 1'b0;
    end else if (commit) begin
      digit_q <= digit_nx;
      start_q <= start_nx;
      stop_q  <= stop_nx;
      clear_q <= clear_nx;
    end
  end

  assign kp.startn = ~start_q;
  assign kp.stopn  = ~stop_q;
  assign kp.clearn = ~clear_q;

`ifdef KEYPAD_ONESHOT_EN
  logic [9:0] pulse_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pulse_q <= '0;
    end else if (commit && (digit_nx != digit_q)) begin
      pulse_q <= digit_nx;
    end else begin
      pulse_q <= '0;
    end
  end

  assign kp.keypad = pulse_q;
`else
  assign kp.keypad = digit_q;
`endif

endmodule

// File: tb/tb_microwave_keypad_scanner.sv
// Table-driven bench with a matrix model and an expected-result queue.
module tb_microwave_keypad_scanner;

  localparam logic [12:0] IDLE = {10'd0, 3'b111};

  typedef struct {
    string       name;
    logic [15:0] keys;
    logic [9:0]  keypad;
    logic [2:0]  btn_n;
  } vec_t;

  logic        clock;
  logic        resetn;
  logic [15:0] keys;
  logic        bounce_en;
  logic        bounce_lvl;
  int          checks;
  int          errors;
  vec_t        table_v[15];
  vec_t        sb[$];

  microwave_keypad_scanner_if kif ();

  microwave_keypad_scanner dut (
    .clock  (clock),
    .resetn (resetn),
    .kp     (kif)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      kif.rows_n[r] = ~|(keys[4*r +: 4] & ~kif.cols_n);
    end
    if (bounce_en) kif.rows_n[2] = bounce_lvl;
  end

  function automatic logic [12:0] outs();
    return {kif.keypad, kif.startn, kif.stopn, kif.clearn};
  endfunction

  task automatic check(input string name, input logic [12:0] act,
                       input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic poll(input string name, input logic [12:0] exp,
                      input int limit);
    int n = 0;
    bit hit = 1'b0;
    while (n < limit && !hit) begin
      @(negedge clock);
      n++;
      if (outs() === exp) hit = 1'b1;
    end
    check(name, outs(), exp);
  endtask

  task automatic hold(input string name, input logic [12:0] exp,
                      input int cycles);
    logic [12:0] seen = exp;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (outs() !== exp) seen = outs();
    end
    check(name, seen, exp);
  endtask

  function automatic logic [9:0] lvl(input logic [9:0] kp);
`ifdef KEYPAD_ONESHOT_EN
    return 10'd0;
`else
    return kp;
`endif
  endfunction

  initial begin
    vec_t e;
    int   hi;
    checks     = 0;
    errors     = 0;
    keys       = '0;
    bounce_en  = 1'b0;
    bounce_lvl = 1'b1;
    resetn     = 1'b0;

    table_v[0]  = '{"key3",       16'h0004, 10'b0000001000, 3'b111};
    table_v[1]  = '{"rel3",       16'h0000, 10'b0000000000, 3'b111};
    table_v[2]  = '{"key0",       16'h2000, 10'b0000000001, 3'b111};
    table_v[3]  = '{"start",      16'h0008, 10'b0000000000, 3'b011};
    table_v[4]  = '{"rel_start",  16'h0000, 10'b0000000000, 3'b111};
    table_v[5]  = '{"stop",       16'h0080, 10'b0000000000, 3'b101};
    table_v[6]  = '{"clear",      16'h0800, 10'b0000000000, 3'b110};
    table_v[7]  = '{"key1",       16'h0001, 10'b0000000010, 3'b111};
    table_v[8]  = '{"key5",       16'h0020, 10'b0000100000, 3'b111};
    table_v[9]  = '{"key8",       16'h0200, 10'b0100000000, 3'b111};
    table_v[10] = '{"chord_1_5",  16'h0021, 10'b0000000000, 3'b111};
    table_v[11] = '{"masked_r3c0",16'h1000, 10'b0000000000, 3'b111};
    table_v[12] = '{"key6_masked",16'h1040, 10'b0001000000, 3'b111};
    table_v[13] = '{"chord_4_stop",16'h0090,10'b0000000000, 3'b111};
    table_v[14] = '{"rel_all",    16'h0000, 10'b0000000000, 3'b111};

    repeat (3) @(negedge clock);
    check("reset_outs", outs(), IDLE);
    check("reset_cols", {9'd0, kif.cols_n}, {9'd0, 4'b1110});

    resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [3:0] one = 4'b0001;
      if (k > 0) @(negedge clock);
      check($sformatf("scan_cols_%0d", k), {9'd0, kif.cols_n},
            {9'd0, ~(one << ((k / 3) % 4))});
    end
    hold("idle_outs", IDLE, 40);

`ifndef KEYPAD_ONESHOT_EN
    keys = 16'h0004;
    poll("key3_press", {10'b0000001000, 3'b111}, 39);
    hold("key3_held", {10'b0000001000, 3'b111}, 60);
    keys = 16'h0000;
    poll("key3_release", IDLE, 39);
    hold("key3_idle", IDLE, 20);
`endif

    foreach (table_v[i]) begin
      keys = table_v[i].keys;
      sb.push_back(table_v[i]);
      repeat (60) @(negedge clock);
      e = sb.pop_front();
      check(e.name, outs(), {lvl(e.keypad), e.btn_n});
    end

    keys = 16'h0022;
    hold("chord_2_5_hold", IDLE, 80);
    keys = 16'h0000;
    repeat (60) @(negedge clock);

    keys       = 16'h0400;
    bounce_en  = 1'b1;
    bounce_lvl = 1'b0;
    for (int i = 0; i < 12; i++) begin
      hold("bounce_quiet", IDLE, 5);
      bounce_lvl = ~bounce_lvl;
    end
    bounce_en = 1'b0;
    poll("key9_settled", {10'b1000000000, 3'b111}, 39);
    keys = 16'h0000;
    repeat (60) @(negedge clock);

    keys = 16'h0080;
    repeat (60) @(negedge clock);
    check("stop_committed", outs(), {10'd0, 3'b101});
    #2 resetn = 1'b0;
    #1;
    check("async_reset_outs", outs(), IDLE);
    check("async_reset_cols", {9'd0, kif.cols_n}, {9'd0, 4'b1110});
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (60) @(negedge clock);
    check("stop_after_reset", outs(), {10'd0, 3'b101});
    keys = 16'h0000;
    repeat (60) @(negedge clock);

    keys = 16'h0100;
    hi   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (kif.keypad[7] === 1'b1) hi++;
    end
`ifdef KEYPAD_ONESHOT_EN
    check("key7_pulse_cycles", 13'(hi), 13'd1);
`else
    check("key7_level_cycles", 13'((hi >= 61) ? 1 : 0), 13'd1);
`endif
    keys = 16'h0000;
    repeat (60) @(negedge clock);
    check("final_idle", outs(), IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
